// File: rtl/sha256_pkg.sv
// ============================================================================
// Module   : sha256_pkg
// Purpose  : Shared types and constants for the SHA-256 message padder:
//            padder state encoding, block geometry and the 512-bit block type.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

    localparam int         BLOCK_BYTES = 64;     // bytes per 512-bit block
    localparam int         LEN_OFFSET  = 56;     // first byte of the length field
    localparam logic [7:0] PAD_BYTE    = 8'h80;  // terminator written after the message

    // Byte 0 of a block sits at [511:504], so W0 = [511:480].
    typedef logic [511:0] block_t;

    typedef enum logic [2:0] {
        FILL  = 3'd0,   // accepting message bytes
        PAD80 = 3'd1,   // writing the 0x80 terminator
        ZFULL = 3'd2,   // zero-filling to the end of a block with no room for the length
        ZERO  = 3'd3,   // zero-filling up to the length field
        LEN   = 3'd4,   // writing the 64-bit big-endian bit length
        OUT   = 3'd5    // presenting a block downstream
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sha256_blk_buf.sv
// ============================================================================
// Module   : sha256_blk_buf
// Purpose  : 64 x 8 byte register file that assembles one SHA-256 block.
//            One byte-write port, one 8-byte length-field write port and a
//            synchronous clear. Presents the block flattened big-endian.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            clr              - synchronous clear of every byte
//            byte_we/idx/data - single byte write
//            len_we/len_data  - write len_data big-endian into bytes 56..63
//            blk              - flattened block, byte 0 at [511:504]
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_blk_buf
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_we,
    input  logic [5:0]  byte_idx,
    input  logic [7:0]  byte_data,
    input  logic        len_we,
    input  logic [63:0] len_data,
    output block_t      blk
);

    logic [7:0] r_mem [BLOCK_BYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '{default: 8'h00};
        end else if (clr) begin
            r_mem <= '{default: 8'h00};
        end else begin
            if (byte_we) begin
                r_mem[byte_idx] <= byte_data;
            end
            if (len_we) begin
                for (int i = 0; i < 8; i++) begin
                    r_mem[6'(LEN_OFFSET + i)] <= len_data[63 - 8*i -: 8];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_flat
            assign blk[511 - 8*g -: 8] = r_mem[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sha256_msg_padder.sv
// ============================================================================
// Module   : sha256_msg_padder
// Purpose  : Accepts a message as a byte stream, applies SHA-256 padding
//            (0x80, zero fill, 64-bit big-endian bit length) and emits
//            512-bit blocks over a valid/ready handshake.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            in_valid/ready/data   - message byte stream
//            in_last               - marks the final message byte
//            in_empty              - (optional) request a zero-length message
//            blk_valid/ready       - block handshake
//            blk_data              - 512-bit block, byte 0 at [511:504]
//            blk_last              - final block of the message
// Params   : LEN_W (16..64) - bit-length counter width, wraps mod 2^LEN_W
// Config   : SHA256_PADDER_EMPTY_EN - adds in_empty for empty messages
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
`ifdef SHA256_PADDER_EMPTY_EN
    input  logic         in_empty,
`endif
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    localparam logic [5:0] c_IDX_LAST = 6'(BLOCK_BYTES - 1);
    localparam logic [5:0] c_IDX_LEN  = 6'(LEN_OFFSET);

    state_t             r_state, w_state_nxt;
    state_t             r_ret,   w_ret_nxt;   // where to go after a non-final OUT
    logic [5:0]         r_idx,   w_idx_nxt;
    logic [LEN_W-1:0]   r_len,   w_len_nxt;
    logic               r_last,  w_last_nxt;  // block in OUT is the message's final one

    logic               w_clr;
    logic               w_byte_we;
    logic [7:0]         w_byte_data;
    logic               w_len_we;
    logic [63:0]        w_len_field;
    logic               w_in_fire;
    logic               w_blk_fire;
    block_t             w_blk;

    // Gate with rst_n so the byte interface reads not-ready while held in reset.
    assign in_ready    = rst_n && (r_state == FILL);
    assign blk_valid   = (r_state == OUT);
    assign blk_last    = (r_state == OUT) && r_last;
    assign blk_data    = w_blk;

    assign w_in_fire   = in_valid && in_ready;
    assign w_blk_fire  = blk_valid && blk_ready;
    assign w_len_field = 64'(r_len);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_ret   <= FILL;
            r_idx   <= '0;
            r_len   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ret   <= w_ret_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ret_nxt   = r_ret;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_last_nxt  = r_last;
        w_clr       = 1'b0;
        w_byte_we   = 1'b0;
        w_byte_data = 8'h00;
        w_len_we    = 1'b0;

        case (r_state)
            FILL: begin
                if (w_in_fire) begin
                    w_byte_we   = 1'b1;
                    w_byte_data = in_data;
                    w_len_nxt   = r_len + LEN_W'(8);
                    if (r_idx == c_IDX_LAST) begin
                        // Block full: ship it; padding (if any) starts in the next block.
                        w_state_nxt = OUT;
                        w_last_nxt  = 1'b0;
                        w_ret_nxt   = in_last ? PAD80 : FILL;
                    end else begin
                        w_idx_nxt = r_idx + 6'd1;
                        if (in_last) begin
                            w_state_nxt = PAD80;
                        end
                    end
                end
`ifdef SHA256_PADDER_EMPTY_EN
                else if (in_empty && (r_idx == 6'd0)) begin
                    w_state_nxt = PAD80;
                end
`endif
            end

            PAD80: begin
                w_byte_we   = 1'b1;
                w_byte_data = PAD_BYTE;
                if (r_idx == c_IDX_LAST) begin
                    // Terminator filled the block; length goes in a fresh block.
                    w_state_nxt = OUT;
                    w_last_nxt  = 1'b0;
                    w_ret_nxt   = ZERO;
                end else begin
                    w_idx_nxt   = r_idx + 6'd1;
                    // New index <= 56 leaves room for the length field in this block.
                    w_state_nxt = (r_idx < c_IDX_LEN) ? ZERO : ZFULL;
                end
            end

            ZFULL: begin
                w_byte_we = 1'b1;
                if (r_idx == c_IDX_LAST) begin
                    w_state_nxt = OUT;
                    w_last_nxt  = 1'b0;
                    w_ret_nxt   = ZERO;
                end else begin
                    w_idx_nxt = r_idx + 6'd1;
                end
            end

            ZERO: begin
                if (r_idx == c_IDX_LEN) begin
                    w_state_nxt = LEN;
                end else begin
                    w_byte_we = 1'b1;
                    w_idx_nxt = r_idx + 6'd1;
                end
            end

            LEN: begin
                w_len_we    = 1'b1;
                w_state_nxt = OUT;
                w_last_nxt  = 1'b1;
                w_ret_nxt   = FILL;
            end

            OUT: begin
                if (w_blk_fire) begin
                    w_clr     = 1'b1;
                    w_idx_nxt = '0;
                    if (r_last) begin
                        w_len_nxt   = '0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = FILL;
                    end else begin
                        w_state_nxt = r_ret;
                    end
                end
            end

            default: begin
                w_state_nxt = FILL;
            end
        endcase
    end

    sha256_blk_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (w_clr),
        .byte_we   (w_byte_we),
        .byte_idx  (r_idx),
        .byte_data (w_byte_data),
        .len_we    (w_len_we),
        .len_data  (w_len_field),
        .blk       (w_blk)
    );

endmodule

`default_nettype wire

// File: doc/sha256_msg_padder.md
Name: sha256_msg_padder

Overview:
- Producer side of the SHA-256 compression datapath.
- Accepts the message as a byte stream and applies FIPS 180-4 padding: a 0x80 byte, zero fill, then the 64-bit big-endian bit length.
- Emits 512-bit blocks over a valid/ready handshake to the round core, which uses the Ch/Maj/Sigma functions.
- Sits between the host byte interface and the message-schedule/compression unit.

Parameters:
- LEN_W, 64: width of the internal bit-length counter. Legal range 16..64. The value is zero-extended into the 64-bit length field; upper bits wrap mod 2^LEN_W.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  padder can accept a byte
- in_data  input  8  message byte
- in_last  input  1  qualifies the final message byte (valid only with in_valid)
- blk_valid  output  1  blk_data holds a complete block
- blk_ready  input  1  downstream accepts the block
- blk_data  output  512  block; byte 0 at [511:504], so W0 = [511:480]
- blk_last  output  1  final block of the message; valid with blk_valid

Behaviour:
- Reset (async, rst_n=0):
  - State = FILL; byte index idx = 0; length counter = 0.
  - Buffer cleared to zero.
  - Outputs: in_ready=0 during reset, blk_valid=0, blk_last=0, blk_data=0.
- Handshakes:
  - A byte transfers when in_valid & in_ready.
  - A block transfers when blk_valid & blk_ready.
  - blk_valid, blk_data and blk_last are held stable until the block is accepted.
  - in_ready is 1 only in FILL.
- FILL:
  - Each accepted byte is written at idx; idx increments; length counter increments by 8.
  - Accepted at idx 63, not last → OUT (blk_last=0). After acceptance: buffer cleared, idx=0, return to FILL.
  - Accepted with in_last at idx 63 → OUT (blk_last=0), then PAD80 at idx 0.
  - Accepted with in_last at idx < 63 → PAD80 at idx+1.
- PAD80 (1 cycle): write 0x80 at idx, then idx++.
  - If the new idx ≤ 56 → ZERO.
  - If the new idx > 56 → ZFULL.
- ZFULL: write zeros one byte per cycle until idx = 63 is written.
  - Then OUT (blk_last=0).
  - After acceptance: buffer cleared, idx=0, go to ZERO.
- ZERO: write zeros one byte per cycle while idx < 56; then LEN.
- LEN (1 cycle): write the length counter, big-endian, into bytes 56..63; then OUT with blk_last=1.
- OUT:
  - blk_valid=1; no input is accepted.
  - On acceptance of the final block: length counter = 0, idx = 0, buffer cleared, state FILL.
- Latency, in_last to final blk_valid:
  - idx < 56 path: 1 + (56 − (idx+1)) + 1 cycles.
  - ZFULL path: 2 + (63 − idx) + 56 + 1 cycles minimum, plus any downstream stall.
- Boundary cases:
  - 55-byte message → one block.
  - 56..63-byte message → two blocks.
  - 64-byte message → 0x80 starts the second block.
  - Length wraps mod 2^LEN_W; no error is flagged.
- Reset mid-message or mid-OUT: everything is discarded, including any partial block. No block is emitted after reset until new input arrives.
- Empty messages are not supported without the optional feature (in_last always carries a data byte).

Optional Feature:
- Macro: SHA256_PADDER_EMPTY_EN.
- When defined:
  - Adds input in_empty (1 bit).
  - A pulse in FILL with idx=0 and in_valid=0 jumps directly to PAD80 with length 0.
  - Result: the single block 0x80 followed by 63 zero bytes, blk_last=1.
  - in_empty is ignored in any other state, or when idx≠0.
- When undefined: the port is absent and a zero-length message cannot be expressed.

Decomposition:
- Shared package sha256_pkg:
  - State encoding (FILL, PAD80, ZFULL, ZERO, LEN, OUT).
  - Constants: BLOCK_BYTES=64, LEN_OFFSET=56, PAD_BYTE=8'h80.
  - Block type typedef (512-bit).
- One natural sub-module: sha256_blk_buf.
  - 64×8 byte register file with a byte-write port and a synchronous clear.
  - Presents the flattened big-endian 512-bit output.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63), blk_ready=1 → one block: 0x61626380, zeros, final word 0x00000018; blk_last=1.
- 55 bytes of 0x00 → one block: byte 55 = 0x80, length 0x1B8; blk_last=1.
- 56 bytes of 0xFF → two blocks:
  - Block 1: bytes 0..55 = 0xFF, byte 56 = 0x80, rest zero; blk_last=0.
  - Block 2: zeros with length 0x1C0; blk_last=1.
- 64 bytes 0x00..0x3F → two blocks:
  - Block 1 is the raw data.
  - Block 2 = 0x80, zeros, length 0x200.
- Backpressure: hold blk_ready=0 for 10 cycles in OUT → blk_data and blk_valid stable, in_ready=0; accept on cycle 11 → FILL resumes.
- Assert rst_n low during ZERO of a 3-byte message → blk_valid stays 0. A subsequent "abc" yields exactly the first scenario's block.
